// File: rtl/serial_sub_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl_pkg
//   Shared definitions for the bit-serial subtract controller.
//   Contents:
//     state_e : FSM state encoding (IDLE/RUN/DONE). The fourth code, S_BAD,
//               is unreachable in normal operation and decodes back to IDLE.
// ---------------------------------------------------------------------------
package serial_sub_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_BAD  = 2'd3
   } state_e;

endpackage : serial_sub_ctrl_pkg

// File: rtl/serial_sub_bit.sv
// ---------------------------------------------------------------------------
// serial_sub_bit
//   Combinational 1-bit full subtractor: computes a - b - bin for one bit.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow in
//     diff out 1  difference bit
//     bout out 1  borrow out
// ---------------------------------------------------------------------------
module serial_sub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   always_comb begin
      diff = a ^ b ^ bin;
      // Borrow when b exceeds a outright, or when a==b and a borrow is pending.
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule : serial_sub_bit

// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
//   Bit-serial subtract controller. Runs one serial_sub_bit cell over a
//   WIDTH-bit operand pair, LSB first, one bit per clock, computing
//   diff = a - b - bin.
//   Handshake: start is sampled only in IDLE; a/b/bin are captured on that
//   edge. busy is high throughout RUN; done pulses for one cycle when
//   diff/bout hold the finished result. start in RUN/DONE is dropped.
//   Ports:
//     clk    in   1      clock, rising edge
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      request
//     a      in   WIDTH  minuend
//     b      in   WIDTH  subtrahend
//     bin    in   1      initial borrow-in
//     busy   out  1      high while in RUN
//     done   out  1      one-cycle result-valid pulse
//     diff   out  WIDTH  result register (partial values visible during RUN)
//     bout   out  1      final borrow-out (1 => a < b + bin, unsigned)
//   Internal state_q holds the FSM state for observation.
// ---------------------------------------------------------------------------
module serial_sub_ctrl
   import serial_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   // Terminal count is compared explicitly so non-power-of-2 widths work.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
   logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
   logic               br_q,    br_d;
   logic [WIDTH-1:0]   diff_q,  diff_d;
   logic               bout_q,  bout_d;

   logic               cell_d;
   logic               cell_bo;

   serial_sub_bit u_bit (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (br_q),
      .diff (cell_d),
      .bout (cell_bo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         br_q    <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         br_q    <= br_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      br_d    = br_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = bin;
               cnt_d   = '0;
            end
         end

         S_RUN: begin
            // Result bits enter at the MSB so after WIDTH shifts bit 0 of
            // the operands has landed in diff[0].
            diff_d = {cell_d, diff_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = cell_bo;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               bout_d  = cell_bo;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode registered state only; no input reaches them combinationally.
   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_ctrl
//   Directed checks of serial_sub_ctrl at WIDTH=8 plus an exhaustive sweep
//   of a second instance at WIDTH=5 against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_serial_sub_ctrl;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- WIDTH=8 instance ----------------
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;

   serial_sub_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   // ---------------- WIDTH=5 instance ----------------
   logic       s_start;
   logic [4:0] s_a;
   logic [4:0] s_b;
   logic       s_bin;
   logic       s_busy;
   logic       s_done;
   logic [4:0] s_diff;
   logic       s_bout;

   serial_sub_ctrl #(.WIDTH(5)) dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (s_start),
      .a     (s_a),
      .b     (s_b),
      .bin   (s_bin),
      .busy  (s_busy),
      .done  (s_done),
      .diff  (s_diff),
      .bout  (s_bout)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- WIDTH=8 driver ----------------
   // Accept edge is E0. done must be seen right after E8 (the 9th edge
   // counting the accept edge); busy is seen high after E0..E7.
   task automatic op8(input string tag,
                      input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                      input logic [7:0] ediff, input logic ebout,
                      input bit perturb, input bit pulse);
      int  busy_cnt;
      int  edges;
      int  extra;
      bit  got;
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      busy_cnt = busy ? 1 : 0;
      got      = 1'b0;
      edges    = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         if (perturb && i == 3) begin
            a = ~ia; b = 8'h55; bin = ~ibin;
         end
         start = pulse && (i == 2 || i == 5);
         @(posedge clk); #1;
         if (done) begin
            got   = 1'b1;
            edges = i;
         end else if (busy) begin
            busy_cnt++;
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 64'(got), 64'd1);
      check({tag, "_latency"},   64'(edges), 64'd8);
      check({tag, "_busy_cyc"},  64'(busy_cnt), 64'd8);
      check({tag, "_diff"},      64'(diff), 64'(ediff));
      check({tag, "_bout"},      64'(bout), 64'(ebout));
      if (pulse) begin
         // start during DONE must be ignored as well
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         extra = 0;
         repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
         end
         check({tag, "_no_retrigger"}, 64'(extra), 64'd0);
         check({tag, "_diff_hold"},    64'(diff), 64'(ediff));
      end else begin
         @(posedge clk); #1;   // leave DONE so the next start is accepted
      end
   endtask

   // ---------------- WIDTH=5 driver ----------------
   task automatic op5(input logic [4:0] ia, input logic [4:0] ib, input logic ibin);
      logic [5:0] ref6;
      bit         got;
      ref6 = {1'b0, ia} - {1'b0, ib} - {5'd0, ibin};
      s_a = ia; s_b = ib; s_bin = ibin; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      got = 1'b0;
      for (int i = 1; i <= 12 && !got; i++) begin
         @(posedge clk); #1;
         if (s_done) got = 1'b1;
      end
      check("w5_done_seen", 64'(got), 64'd1);
      check("w5_result", 64'({s_bout, s_diff}), 64'(ref6));
      @(posedge clk); #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n   = 1'b0;
      start   = 1'b0; a = '0; b = '0; bin = 1'b0;
      s_start = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_diff", 64'(diff), 64'd0);
      check("rst_bout", 64'(bout), 64'd0);
      check("rst_w5",   64'({s_busy, s_done, s_bout, s_diff}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op8("t5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
      op8("t00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      op8("tff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      op8("t10_0f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      op8("tmid",   8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
      op8("t80_7f", 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
      op8("tpulse", 8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0, 1'b1);

      // Abort mid-RUN with an asynchronous reset between clock edges.
      a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("pre_abort_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_diff", 64'(diff), 64'd0);
      check("abort_bout", 64'(bout), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      op8("post_rst", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);

      // Exhaustive WIDTH=5 sweep
      for (int ia = 0; ia < 32; ia++) begin
         for (int ib = 0; ib < 32; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               op5(5'(ia), 5'(ib), 1'(ic));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_serial_sub_ctrl
